// File: rtl/sync_fifo_stream_reader.sv
// Read-side engine for a standard-mode sync_fifo: issues rd_en on credit, absorbs the
// 1-cycle read latency in a 3-entry buffer and presents a valid/ready stream with framing.
module sync_fifo_stream_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [LEN_W-1:0] i_frame_len,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_dout,
    output logic             o_fifo_rd_en,
    output logic             o_m_valid,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_m_last,
    input  logic             i_m_ready,
    output logic [1:0]       o_buf_cnt
);

    localparam int unsigned DEPTH   = 3;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CRED_W  = 3;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [WIDTH-1:0] buf_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [CRED_W-1:0] credit_used;
    logic              push;
    logic              pop;
    logic [LEN_W-1:0]  cur_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts words already buffered plus the one possibly returning from the FIFO
    assign credit_used  = CRED_W'(cnt_q) + CRED_W'(inflight_q);
    assign o_fifo_rd_en = i_rst_n & ~i_fifo_empty & ~i_flush & (credit_used < CRED_W'(DEPTH));

    assign push      = inflight_q & ~i_flush;
    assign o_m_valid = (cnt_q != '0);
    assign pop       = o_m_valid & i_m_ready;
    assign o_m_data  = buf_q[head_q];
    assign o_buf_cnt = cnt_q;

    // Frame length is sampled live only on the first beat, then held for the rest of the frame
    assign cur_len  = (beat_cnt_q == '0) ? i_frame_len : len_q;
    assign o_m_last = o_m_valid & (cur_len != '0) & (beat_cnt_q == cur_len - LEN_W'(1));

    // Next-state logic
    always_comb begin
        buf_d      = buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        inflight_d = o_fifo_rd_en;

        if (i_flush) begin
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
            beat_cnt_d = '0;
        end else begin
            if (push) begin
                buf_d[tail_q] = i_fifo_dout;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (pop) begin
                if (beat_cnt_q == '0) begin
                    len_d = i_frame_len;
                end
                beat_cnt_d = o_m_last ? '0 : beat_cnt_q + LEN_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= buf_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

    // The credit rule must never let a returning word land in a full buffer
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Directed bench for sync_fifo_stream_reader with a behavioural standard-mode FIFO model.
module tb_sync_fifo_stream_reader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LEN_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic [LEN_W-1:0] i_frame_len = '0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             o_fifo_rd_en;
    logic             o_m_valid;
    logic [WIDTH-1:0] o_m_data;
    logic             o_m_last;
    logic             i_m_ready = 1'b0;
    logic [1:0]       o_buf_cnt;

    logic [31:0] fifo_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_stream_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_frame_len  (i_frame_len),
        .i_fifo_empty (fifo_empty),
        .i_fifo_dout  (fifo_dout),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_m_valid    (o_m_valid),
        .o_m_data     (o_m_data),
        .o_m_last     (o_m_last),
        .i_m_ready    (i_m_ready),
        .o_buf_cnt    (o_buf_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Standard-mode FIFO: dout updates the edge after rd_en, empty reflects post-pop contents
    always @(posedge i_clk) begin
        if (o_fifo_rd_en && fifo_q.size() != 0) begin
            fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(base + 32'(k));
        end
    endtask

    // Wait (bounded) for a valid beat with ready high, check it, and step past its handshake
    task automatic recv(input string tag, input logic [31:0] exp_d, input logic exp_l);
        int t = 0;
        while (!o_m_valid && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        check({tag, "_valid"}, 32'(o_m_valid), 32'd1);
        check({tag, "_data"},  o_m_data, exp_d);
        check({tag, "_last"},  32'(o_m_last), 32'(exp_l));
        @(negedge i_clk);
    endtask

    initial begin
        int rd_pulses;

        // T1: reset held with FIFO non-empty
        @(negedge i_clk);
        push_words(32'h10, 8);
        repeat (3) @(negedge i_clk);
        check("t1_rd_en",  32'(o_fifo_rd_en), 32'd0);
        check("t1_valid",  32'(o_m_valid),    32'd0);
        check("t1_data",   o_m_data,          32'd0);
        check("t1_bufcnt", 32'(o_buf_cnt),    32'd0);
        check("t1_last",   32'(o_m_last),     32'd0);

        // T2: full-rate streaming, unframed
        i_m_ready   = 1'b1;
        i_frame_len = '0;
        i_rst_n     = 1'b1;
        #1;
        check("t2_rd_cycle0", 32'(o_fifo_rd_en), 32'd1);
        @(negedge i_clk);
        check("t2_valid_cycle1", 32'(o_m_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check($sformatf("t2_valid_%0d", i), 32'(o_m_valid), 32'd1);
            check($sformatf("t2_data_%0d", i),  o_m_data, 32'h10 + 32'(i));
            check($sformatf("t2_last_%0d", i),  32'(o_m_last), 32'd0);
        end
        @(negedge i_clk);
        check("t2_drained", 32'(o_m_valid), 32'd0);

        // T3: backpressure fills the buffer with exactly three reads
        i_m_ready = 1'b0;
        push_words(32'h10, 8);
        rd_pulses = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_fifo_rd_en) rd_pulses++;
        end
        check("t3_rd_pulses", 32'(rd_pulses), 32'd3);
        check("t3_bufcnt",    32'(o_buf_cnt), 32'd3);
        check("t3_head",      o_m_data,       32'h10);
        @(negedge i_clk);
        check("t3_head_hold", o_m_data,       32'h10);
        i_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            recv($sformatf("t3_beat%0d", i), 32'h10 + 32'(i), 1'b0);
        end
        check("t3_drained", 32'(o_m_valid), 32'd0);

        // T5: flush with a full buffer; framing restarts with len=2
        i_m_ready   = 1'b0;
        i_frame_len = LEN_W'(2);
        push_words(32'h10, 8);
        repeat (8) @(negedge i_clk);
        check("t5_full", 32'(o_buf_cnt), 32'd3);
        i_flush = 1'b1;
        #1;
        check("t5_rd_in_flush", 32'(o_fifo_rd_en), 32'd0);
        @(negedge i_clk);
        i_flush = 1'b0;
        check("t5_valid", 32'(o_m_valid), 32'd0);
        check("t5_bufcnt", 32'(o_buf_cnt), 32'd0);
        i_m_ready = 1'b1;
        recv("t5_b0", 32'h13, 1'b0);
        recv("t5_b1", 32'h14, 1'b1);
        recv("t5_b2", 32'h15, 1'b0);
        recv("t5_b3", 32'h16, 1'b1);
        recv("t5_b4", 32'h17, 1'b0);

        // T4: len=3 framing, mid-frame length change, len=1
        i_frame_len = LEN_W'(3);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        push_words(32'hA0, 7);
        for (int i = 0; i < 7; i++) begin
            recv($sformatf("t4_a%0d", i), 32'hA0 + 32'(i), (i == 2) || (i == 5));
        end
        i_frame_len = LEN_W'(5);
        push_words(32'hA7, 2);
        recv("t4_a7", 32'hA7, 1'b0);
        recv("t4_a8", 32'hA8, 1'b1);
        push_words(32'hB0, 5);
        for (int i = 0; i < 5; i++) begin
            recv($sformatf("t4_b%0d", i), 32'hB0 + 32'(i), i == 4);
        end
        i_frame_len = LEN_W'(1);
        push_words(32'hE0, 2);
        recv("t4_len1_0", 32'hE0, 1'b1);
        recv("t4_len1_1", 32'hE1, 1'b1);

        // T6: asynchronous reset after two beats of a len=4 frame
        i_frame_len = LEN_W'(4);
        push_words(32'hC0, 4);
        recv("t6_c0", 32'hC0, 1'b0);
        recv("t6_c1", 32'hC1, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_valid",  32'(o_m_valid),    32'd0);
        check("t6_data",   o_m_data,          32'd0);
        check("t6_last",   32'(o_m_last),     32'd0);
        check("t6_bufcnt", 32'(o_buf_cnt),    32'd0);
        check("t6_rd_en",  32'(o_fifo_rd_en), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        push_words(32'hD0, 4);
        recv("t6_d0", 32'hD0, 1'b0);
        recv("t6_d1", 32'hD1, 1'b0);
        recv("t6_d2", 32'hD2, 1'b0);
        recv("t6_d3", 32'hD3, 1'b1);
        check("t6_drained", 32'(o_m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
